lemmings_swarm: RTL and testbench

- Parametrised multi-channel walker FSM: next generation of the single-lemming walk-left/walk-right controller.
- Instantiates N independent Moore walker channels. Each channel adds falling, digging and splat (death-after-long-fall) behaviour to the bump-reversal walking.
- An aggregate live-count output feeds the scoreboard/status logic in the same game-controller cluster.

---
 rtl/lemmings_swarm_if.sv | 26 ++
 rtl/lemmings_swarm.sv | 98 +++++++++
 tb/tb_lemmings_swarm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lemmings_swarm_if.sv
// Per-channel obstacle/ground/dig inputs and walker status outputs for lemmings_swarm.
interface lemmings_swarm_if #(
    parameter int N_LEMMINGS = 4
);
    localparam int AW = $clog2(N_LEMMINGS + 1);

    logic [N_LEMMINGS-1:0] bump_left;
    logic [N_LEMMINGS-1:0] bump_right;
    logic [N_LEMMINGS-1:0] ground;
    logic [N_LEMMINGS-1:0] dig;
    logic [N_LEMMINGS-1:0] walk_left;
    logic [N_LEMMINGS-1:0] walk_right;
    logic [N_LEMMINGS-1:0] aaah;
    logic [N_LEMMINGS-1:0] digging;
    logic [AW-1:0]         alive_count;

    modport master (
        output bump_left, bump_right, ground, dig,
        input  walk_left, walk_right, aaah, digging, alive_count
    );

    modport slave (
        input  bump_left, bump_right, ground, dig,
        output walk_left, walk_right, aaah, digging, alive_count
    );
endinterface

// File: rtl/lemmings_swarm.sv
// N independent Moore walker channels (walk/fall/dig/splat) with a live-channel popcount.
module lemmings_swarm #(
    parameter int N_LEMMINGS   = 4,
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             areset_n,
    lemmings_swarm_if.slave  sw
);
    localparam int AW = $clog2(N_LEMMINGS + 1);

    localparam logic [2:0] ST_WL     = 3'd0;
    localparam logic [2:0] ST_WR     = 3'd1;
    localparam logic [2:0] ST_FALL_L = 3'd2;
    localparam logic [2:0] ST_FALL_R = 3'd3;
    localparam logic [2:0] ST_DIG_L  = 3'd4;
    localparam logic [2:0] ST_DIG_R  = 3'd5;
    localparam logic [2:0] ST_SPLAT  = 3'd6;

    localparam logic [CNT_W-1:0] SPLAT_TH = CNT_W'(SPLAT_CYCLES);

    logic [2:0]       state_q [N_LEMMINGS];
    logic [2:0]       state_d [N_LEMMINGS];
    logic [CNT_W-1:0] cnt_q   [N_LEMMINGS];
    logic [CNT_W-1:0] cnt_d   [N_LEMMINGS];

    logic [N_LEMMINGS-1:0] wl_o, wr_o, fall_o, dig_o;
    logic [AW-1:0]         alive;

    // cnt_d defaults to zero; only a channel that stays in FALL_x keeps counting
    always_comb begin
        for (int unsigned i = 0; i < N_LEMMINGS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                ST_WL: begin
                    if (!sw.ground[i])        state_d[i] = ST_FALL_L;
                    else if (sw.dig[i])       state_d[i] = ST_DIG_L;
                    else if (sw.bump_left[i]) state_d[i] = ST_WR;
                end
                ST_WR: begin
                    if (!sw.ground[i])         state_d[i] = ST_FALL_R;
                    else if (sw.dig[i])        state_d[i] = ST_DIG_R;
                    else if (sw.bump_right[i]) state_d[i] = ST_WL;
                end
                ST_FALL_L, ST_FALL_R: begin
                    if (!sw.ground[i]) begin
                        cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
                    end else if (cnt_q[i] >= SPLAT_TH) begin
                        state_d[i] = ST_SPLAT;
                    end else begin
                        state_d[i] = (state_q[i] == ST_FALL_L) ? ST_WL : ST_WR;
                    end
                end
                ST_DIG_L: if (!sw.ground[i]) state_d[i] = ST_FALL_L;
                ST_DIG_R: if (!sw.ground[i]) state_d[i] = ST_FALL_R;
                ST_SPLAT: state_d[i] = ST_SPLAT;
                default:  state_d[i] = ST_WL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < N_LEMMINGS; i++) begin
                state_q[i] <= ST_WL;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_LEMMINGS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        wl_o   = '0;
        wr_o   = '0;
        fall_o = '0;
        dig_o  = '0;
        alive  = '0;
        for (int unsigned i = 0; i < N_LEMMINGS; i++) begin
            wl_o[i]   = (state_q[i] == ST_WL);
            wr_o[i]   = (state_q[i] == ST_WR);
            fall_o[i] = (state_q[i] == ST_FALL_L) || (state_q[i] == ST_FALL_R);
            dig_o[i]  = (state_q[i] == ST_DIG_L) || (state_q[i] == ST_DIG_R);
            if (state_q[i] != ST_SPLAT) alive = alive + AW'(1);
        end
    end

    assign sw.walk_left   = wl_o;
    assign sw.walk_right  = wr_o;
    assign sw.aaah        = fall_o;
    assign sw.digging     = dig_o;
    assign sw.alive_count = alive;
endmodule

// File: tb/tb_lemmings_swarm.sv
// Directed bench for lemmings_swarm: per-cycle comparison against a behavioural walker model plus literal checks.
module tb_lemmings_swarm;
    localparam int N     = 4;
    localparam int SPLAT = 20;
    localparam int AW    = $clog2(N + 1);

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    lemmings_swarm_if #(.N_LEMMINGS(N)) sw ();

    lemmings_swarm #(.N_LEMMINGS(N), .SPLAT_CYCLES(SPLAT), .CNT_W(5)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .sw       (sw)
    );

    always #5 clk = ~clk;

    // Model: heading, activity flags and length of the current fall in cycles.
    bit going_right [N];
    bit is_falling  [N];
    bit is_digging  [N];
    bit is_dead     [N];
    int fall_len    [N];

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < N; i++) begin
                going_right[i] = 0; is_falling[i] = 0; is_digging[i] = 0;
                is_dead[i] = 0; fall_len[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (is_dead[i]) begin
                end else if (is_falling[i]) begin
                    if (!sw.ground[i]) fall_len[i]++;
                    else if (fall_len[i] > SPLAT) is_dead[i] = 1;
                    else is_falling[i] = 0;
                end else if (!sw.ground[i]) begin
                    is_digging[i] = 0; is_falling[i] = 1; fall_len[i] = 1;
                end else if (is_digging[i]) begin
                end else if (sw.dig[i]) begin
                    is_digging[i] = 1;
                end else if (going_right[i] ? sw.bump_right[i] : sw.bump_left[i]) begin
                    going_right[i] = !going_right[i];
                end
            end
        end
    end

    task automatic check_all(input string tag);
        logic [N-1:0] e_wl, e_wr, e_fa, e_dg;
        int e_alive;
        e_wl = '0; e_wr = '0; e_fa = '0; e_dg = '0; e_alive = 0;
        for (int i = 0; i < N; i++) begin
            if (!is_dead[i]) begin
                e_alive++;
                if (is_falling[i]) e_fa[i] = 1'b1;
                else if (is_digging[i]) e_dg[i] = 1'b1;
                else if (going_right[i]) e_wr[i] = 1'b1;
                else e_wl[i] = 1'b1;
            end
        end
        n_tests++;
        if (sw.walk_left !== e_wl || sw.walk_right !== e_wr || sw.aaah !== e_fa ||
            sw.digging !== e_dg || sw.alive_count !== AW'(e_alive)) begin
            n_fail++;
            $display("FAIL %s t=%0t got wl=%b wr=%b aaah=%b dig=%b alive=%0d expected wl=%b wr=%b aaah=%b dig=%b alive=%0d",
                     tag, $time, sw.walk_left, sw.walk_right, sw.aaah, sw.digging, sw.alive_count,
                     e_wl, e_wr, e_fa, e_dg, e_alive);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) check_all("cycle");

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int cnt;

    initial begin
        sw.bump_left = '0; sw.bump_right = '0; sw.dig = '0; sw.ground = '1;
        step(2);
        areset_n = 1'b1;
        step(2);
        chk("reset_walk_left", 32'(sw.walk_left), 32'hF);
        chk("reset_alive", 32'(sw.alive_count), 32'd4);

        sw.bump_left[2] = 1'b1; step(1); sw.bump_left[2] = 1'b0;
        chk("bump_ch2_wr", 32'(sw.walk_right), 32'h4);
        chk("bump_ch2_wl", 32'(sw.walk_left), 32'hB);

        // 20-cycle fall survives
        sw.ground[0] = 1'b0; cnt = 0;
        repeat (20) begin step(1); if (sw.aaah[0]) cnt++; end
        sw.ground[0] = 1'b1; step(1);
        chk("ch0_fall_len", 32'(cnt), 32'd20);
        chk("ch0_survive_wl", 32'(sw.walk_left[0]), 32'd1);
        chk("ch0_alive", 32'(sw.alive_count), 32'd4);

        // 21-cycle fall from WR splats
        sw.bump_left[1] = 1'b1; step(1); sw.bump_left[1] = 1'b0;
        chk("ch1_wr", 32'(sw.walk_right[1]), 32'd1);
        sw.ground[1] = 1'b0; cnt = 0;
        repeat (21) begin step(1); if (sw.aaah[1]) cnt++; end
        sw.ground[1] = 1'b1; step(1);
        chk("ch1_fall_len", 32'(cnt), 32'd21);
        chk("ch1_splat_alive", 32'(sw.alive_count), 32'd3);
        sw.bump_left[1] = 1'b1; sw.bump_right[1] = 1'b1; sw.dig[1] = 1'b1; step(3);
        sw.bump_left[1] = 1'b0; sw.bump_right[1] = 1'b0; sw.dig[1] = 1'b0; sw.ground[1] = 1'b0; step(2);
        sw.ground[1] = 1'b1;
        chk("ch1_dead_outputs",
            {28'd0, sw.walk_left[1], sw.walk_right[1], sw.aaah[1], sw.digging[1]}, 32'd0);

        // dig beats bump, then fall from dig and land walking left
        sw.dig[3] = 1'b1; sw.bump_left[3] = 1'b1; step(1);
        sw.dig[3] = 1'b0; sw.bump_left[3] = 1'b0;
        chk("ch3_digging", 32'(sw.digging[3]), 32'd1);
        sw.ground[3] = 1'b0; step(1);
        chk("ch3_aaah", 32'(sw.aaah[3]), 32'd1);
        step(2); sw.ground[3] = 1'b1; step(1);
        chk("ch3_land_wl", 32'(sw.walk_left[3]), 32'd1);

        // fall beats dig
        sw.ground[3] = 1'b0; sw.dig[3] = 1'b1; step(1);
        chk("ch3_fall_not_dig", {30'd0, sw.aaah[3], sw.digging[3]}, 32'd2);
        sw.ground[3] = 1'b1; sw.dig[3] = 1'b0; step(1);

        // both bumps in WR -> WL
        sw.bump_left[2] = 1'b1; sw.bump_right[2] = 1'b1; step(1);
        sw.bump_left[2] = 1'b0; sw.bump_right[2] = 1'b0;
        chk("ch2_both_bumps_wl", 32'(sw.walk_left[2]), 32'd1);

        // second splat, then ch0 mid-fall, then asynchronous reset between edges
        sw.ground[2] = 1'b0; step(25); sw.ground[2] = 1'b1; step(1);
        chk("two_splat_alive", 32'(sw.alive_count), 32'd2);
        sw.ground[0] = 1'b0; step(5);
        chk("ch0_midfall", 32'(sw.aaah[0]), 32'd1);
        #2 areset_n = 1'b0;
        #1;
        check_all("async_reset");
        chk("async_walk_left", 32'(sw.walk_left), 32'hF);
        chk("async_alive", 32'(sw.alive_count), 32'd4);
        sw.ground = '1;
        step(2);
        areset_n = 1'b1;
        step(1);
        sw.ground[0] = 1'b0; step(20); sw.ground[0] = 1'b1; step(1);
        chk("post_reset_fall_survive", 32'(sw.walk_left[0]), 32'd1);
        chk("post_reset_alive", 32'(sw.alive_count), 32'd4);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
